pipe_hazard_ctrl: RTL and testbench
===================================

// Module: pipe_hazard_ctrl
// PURPOSE
//  Central stall/flush sequencer for the 5-stage pipeline. Drives the Stall/Flush inputs of
//  PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers (all use stall-masks-flush semantics).
//  Resolves load-use hazards, taken-branch/jump squashes and multi-cycle data-memory waits.
//  Keeps a sticky memory-timeout flag and a stall-cycle performance counter.
// PARAMETERS
//  TIMEOUT  255  max cycles in MWAIT before abort; legal range 1..2^16-1
//  CNT_W    32   width of stall_cycles counter
//  RA_W     5    register-address width
// PORTS
//  clk            in   1      clock, rising edge
//  rst            in   1      asynchronous, active-high reset
//  ID_Rs, ID_Rt   in   RA_W   source regs of instruction in ID
//  ID_UsesRs/Rt   in   1      ID instruction actually reads Rs / Rt
//  ID_Jump        in   1      jump decoded in ID (target known in ID)
//  EX_MemRead     in   1      instruction in EX is a load
//  EX_RegWre      in   1      instruction in EX writes a register
//  EX_RegDst      in   RA_W   destination reg of instruction in EX
//  EX_BranchTaken in   1      branch resolved taken in EX
//  MEM_MemAccess  in   1      instruction in MEM performs load/store
//  dmem_ready     in   1      data memory completes access this cycle
//  PC_Stall       out  1      hold PC
//  IFID_Stall/Flush, IDEX_Stall/Flush, EXMEM_Stall/Flush, MEMWB_Stall/Flush  out 1 each
//  mem_err        out  1      sticky: a memory access exceeded TIMEOUT
//  stall_cycles   out  CNT_W  saturating count of cycles with PC_Stall=1
// BEHAVIOUR
//  - Reset (async): state=RUN, wait_cnt=0, mem_err=0, stall_cycles=0; all stall/flush outputs 0.
//  - Stall/flush outputs are combinational from state+inputs (same-cycle effect); state,
//    wait_cnt, mem_err, stall_cycles are registered.
//  - FSM RUN: MEM_MemAccess & !dmem_ready -> MWAIT (stall asserted this cycle);
//    MEM_MemAccess & dmem_ready -> stay RUN, no memory stall (single-cycle hit).
//  - FSM MWAIT: wait_cnt increments each cycle; dmem_ready=1 -> RUN, stalls drop that cycle;
//    wait_cnt==TIMEOUT-1 without ready -> RUN, mem_err<=1, stalls drop (access abandoned).
//    wait_cnt clears on every RUN entry.
//  - Priority, highest first (exactly one rule applies per cycle):
//    1 memwait (MWAIT, or RUN with access & !ready): PC,IFID,IDEX,EXMEM Stall=1;
//      MEMWB Stall=0 Flush=1 (bubble to WB). Branch/jump/load-use ignored (held, re-seen later).
//    2 branch: EX_BranchTaken -> IFID_Flush=1, IDEX_Flush=1, PC_Stall=0 (load target).
//    3 load-use: EX_MemRead & EX_RegWre & EX_RegDst!=0 & ((ID_UsesRs & ID_Rs==EX_RegDst) |
//      (ID_UsesRt & ID_Rt==EX_RegDst)) -> PC_Stall=1, IFID_Stall=1, IDEX_Flush=1.
//      Jump in ID is held (not squashed) during this stall.
//    4 jump: ID_Jump -> IFID_Flush=1 only.
//    5 otherwise all 0.
//  - Reg 0 never creates a hazard. Stall on load-use is exactly 1 cycle.
//  - stall_cycles: +1 on every cycle PC_Stall=1; holds at 2^CNT_W-1.
//  - mem_err cleared only by rst. rst mid-MWAIT: immediate return to RUN, stalls drop.
// STRUCTURE
//  - Shared include pip_defs.vh: FSM state encodings (RUN=0, MWAIT=1), RA_W default,
//    stall/flush bundle bit positions.
//  - One sub-module: mem_wait_fsm (state, wait_cnt, timeout, mem_err); hazard/priority
//    logic and stall counter stay in top.
// TESTING
//  1 lw r5 in EX, ID reads Rs=5 -> 1 cycle PC/IFID stall + IDEX flush; stall_cycles=1.
//  2 lw r0 in EX, ID reads r0 -> no stall; same with ID_UsesRs=0, Rs=5 -> no stall.
//  3 EX_BranchTaken with concurrent load-use -> IFID/IDEX flush only, PC_Stall=0.
//  4 store in MEM, dmem_ready after 3 cycles -> 3 cycles all upstream stalled, MEMWB_Flush=1,
//    4th cycle clear; stall_cycles=3; branch asserted meanwhile applied on release cycle.
//  5 TIMEOUT=4, dmem_ready never -> release after 4 cycles, mem_err=1 sticky until rst.
//  6 rst pulse mid-MWAIT (async, between edges) -> outputs 0 immediately, counters 0.

Source files
------------

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM encodings,
// register-address width default and the stall/flush bundle layout.
package pipe_hazard_ctrl_pkg;

    localparam logic [0:0] ST_RUN   = 1'b0;
    localparam logic [0:0] ST_MWAIT = 1'b1;

    localparam int RA_W_DEF = 5;
    localparam int WC_W     = 16;

    // Bit positions inside the internal stall/flush bundle.
    localparam int B_PC_S    = 0;
    localparam int B_IFID_S  = 1;
    localparam int B_IFID_F  = 2;
    localparam int B_IDEX_S  = 3;
    localparam int B_IDEX_F  = 4;
    localparam int B_EXMEM_S = 5;
    localparam int B_EXMEM_F = 6;
    localparam int B_MEMWB_S = 7;
    localparam int B_MEMWB_F = 8;
    localparam int CTRL_W    = 9;

endpackage

// File: rtl/pipe_hazard_ctrl_mem_wait_fsm.sv
// Data-memory wait sequencer: tracks an outstanding access, counts wait cycles,
// abandons the access at the timeout limit and latches a sticky error.
module mem_wait_fsm
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       mem_access,
    input  logic       dmem_ready,
    output logic [0:0] fsm_state,
    output logic       at_limit,
    output logic       mem_err
);

    localparam logic [WC_W-1:0] LAST = WC_W'(TIMEOUT - 1);

    logic [0:0]      state;
    logic [WC_W-1:0] wait_cnt;

    assign fsm_state = state;
    assign at_limit  = (wait_cnt == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_RUN;
            wait_cnt <= '0;
            mem_err  <= 1'b0;
        end else begin
            case (state)
                ST_RUN: begin
                    wait_cnt <= '0;
                    if (mem_access && !dmem_ready) begin
                        state <= ST_MWAIT;
                    end
                end
                ST_MWAIT: begin
                    if (dmem_ready) begin
                        state    <= ST_RUN;
                        wait_cnt <= '0;
                    end else if (at_limit) begin
                        // Access abandoned: pipeline is released and the error latched.
                        state    <= ST_RUN;
                        wait_cnt <= '0;
                        mem_err  <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + WC_W'(1);
                    end
                end
                default: begin
                    state    <= ST_RUN;
                    wait_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush sequencer for a 5-stage pipeline: memory waits, branch and
// jump squashes, load-use stalls, plus a saturating stall-cycle counter.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 32,
    parameter int RA_W    = RA_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [RA_W-1:0]  ID_Rs,
    input  logic [RA_W-1:0]  ID_Rt,
    input  logic             ID_UsesRs,
    input  logic             ID_UsesRt,
    input  logic             ID_Jump,
    input  logic             EX_MemRead,
    input  logic             EX_RegWre,
    input  logic [RA_W-1:0]  EX_RegDst,
    input  logic             EX_BranchTaken,
    input  logic             MEM_MemAccess,
    input  logic             dmem_ready,
    output logic             PC_Stall,
    output logic             IFID_Stall,
    output logic             IFID_Flush,
    output logic             IDEX_Stall,
    output logic             IDEX_Flush,
    output logic             EXMEM_Stall,
    output logic             EXMEM_Flush,
    output logic             MEMWB_Stall,
    output logic             MEMWB_Flush,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [0:0]        fsm_state;
    logic              at_limit;
    logic              memwait;
    logic              load_use;
    logic [CTRL_W-1:0] ctrl;

    mem_wait_fsm #(.TIMEOUT(TIMEOUT)) u_mem_wait_fsm (
        .clk        (clk),
        .rst        (rst),
        .mem_access (MEM_MemAccess),
        .dmem_ready (dmem_ready),
        .fsm_state  (fsm_state),
        .at_limit   (at_limit),
        .mem_err    (mem_err)
    );

    // The stall starts in the very cycle the miss is seen and drops in the
    // cycle ready arrives or the wait limit is reached.
    assign memwait = (fsm_state == ST_RUN   && MEM_MemAccess && !dmem_ready) ||
                     (fsm_state == ST_MWAIT && !dmem_ready && !at_limit);

    assign load_use = EX_MemRead && EX_RegWre && (EX_RegDst != '0) &&
                      ((ID_UsesRs && ID_Rs == EX_RegDst) ||
                       (ID_UsesRt && ID_Rt == EX_RegDst));

    always_comb begin
        ctrl = '0;
        if (rst) begin
            ctrl = '0;
        end else if (memwait) begin
            ctrl[B_PC_S]    = 1'b1;
            ctrl[B_IFID_S]  = 1'b1;
            ctrl[B_IDEX_S]  = 1'b1;
            ctrl[B_EXMEM_S] = 1'b1;
            ctrl[B_MEMWB_F] = 1'b1;
        end else if (EX_BranchTaken) begin
            ctrl[B_IFID_F]  = 1'b1;
            ctrl[B_IDEX_F]  = 1'b1;
        end else if (load_use) begin
            ctrl[B_PC_S]    = 1'b1;
            ctrl[B_IFID_S]  = 1'b1;
            ctrl[B_IDEX_F]  = 1'b1;
        end else if (ID_Jump) begin
            ctrl[B_IFID_F]  = 1'b1;
        end
    end

    assign PC_Stall    = ctrl[B_PC_S];
    assign IFID_Stall  = ctrl[B_IFID_S];
    assign IFID_Flush  = ctrl[B_IFID_F];
    assign IDEX_Stall  = ctrl[B_IDEX_S];
    assign IDEX_Flush  = ctrl[B_IDEX_F];
    assign EXMEM_Stall = ctrl[B_EXMEM_S];
    assign EXMEM_Flush = ctrl[B_EXMEM_F];
    assign MEMWB_Stall = ctrl[B_MEMWB_S];
    assign MEMWB_Flush = ctrl[B_MEMWB_F];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles <= '0;
        end else if (PC_Stall && stall_cycles != CNT_MAX) begin
            stall_cycles <= stall_cycles + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: a reference model predicts every
// cycle's outputs into a queue that is popped against the DUT after the drive.
module tb_pipe_hazard_ctrl;

    localparam int TO   = 4;
    localparam int CW   = 8;
    localparam int EXPW = 9 + 1 + CW;

    logic          clk;
    logic          rst;
    logic [4:0]    ID_Rs, ID_Rt, EX_RegDst;
    logic          ID_UsesRs, ID_UsesRt, ID_Jump;
    logic          EX_MemRead, EX_RegWre, EX_BranchTaken;
    logic          MEM_MemAccess, dmem_ready;
    logic          PC_Stall, IFID_Stall, IFID_Flush, IDEX_Stall, IDEX_Flush;
    logic          EXMEM_Stall, EXMEM_Flush, MEMWB_Stall, MEMWB_Flush;
    logic          mem_err;
    logic [CW-1:0] stall_cycles;

    typedef struct packed {
        logic [4:0] rs;
        logic [4:0] rt;
        logic       urs;
        logic       urt;
        logic       jump;
        logic       ex_mr;
        logic       ex_rw;
        logic [4:0] dst;
        logic       br;
        logic       acc;
        logic       rdy;
    } stim_t;

    logic [EXPW-1:0] exp_q[$];
    int total = 0;
    int bad   = 0;

    // Reference model state
    int m_state = 0;
    int m_cnt   = 0;
    int m_stall = 0;
    bit m_err   = 0;

    pipe_hazard_ctrl #(.TIMEOUT(TO), .CNT_W(CW), .RA_W(5)) dut (
        .clk            (clk),
        .rst            (rst),
        .ID_Rs          (ID_Rs),
        .ID_Rt          (ID_Rt),
        .ID_UsesRs      (ID_UsesRs),
        .ID_UsesRt      (ID_UsesRt),
        .ID_Jump        (ID_Jump),
        .EX_MemRead     (EX_MemRead),
        .EX_RegWre      (EX_RegWre),
        .EX_RegDst      (EX_RegDst),
        .EX_BranchTaken (EX_BranchTaken),
        .MEM_MemAccess  (MEM_MemAccess),
        .dmem_ready     (dmem_ready),
        .PC_Stall       (PC_Stall),
        .IFID_Stall     (IFID_Stall),
        .IFID_Flush     (IFID_Flush),
        .IDEX_Stall     (IDEX_Stall),
        .IDEX_Flush     (IDEX_Flush),
        .EXMEM_Stall    (EXMEM_Stall),
        .EXMEM_Flush    (EXMEM_Flush),
        .MEMWB_Stall    (MEMWB_Stall),
        .MEMWB_Flush    (MEMWB_Flush),
        .mem_err        (mem_err),
        .stall_cycles   (stall_cycles)
    );

    // clock/reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic stim_t idle();
        stim_t s;
        s = '0;
        return s;
    endfunction

    function automatic logic [8:0] got_ctrl();
        return {PC_Stall, IFID_Stall, IFID_Flush, IDEX_Stall, IDEX_Flush,
                EXMEM_Stall, EXMEM_Flush, MEMWB_Stall, MEMWB_Flush};
    endfunction

    // Expected {ctrl, mem_err, stall_cycles} for the current cycle.
    function automatic logic [EXPW-1:0] model_expect(input stim_t s);
        logic [8:0] c;
        bit mw, lu;
        mw = (m_state == 0 && s.acc && !s.rdy) ||
             (m_state == 1 && !s.rdy && m_cnt != TO - 1);
        lu = s.ex_mr && s.ex_rw && s.dst != 0 &&
             ((s.urs && s.rs == s.dst) || (s.urt && s.rt == s.dst));
        if (mw)        c = 9'b110101001;
        else if (s.br) c = 9'b001010000;
        else if (lu)   c = 9'b110010000;
        else if (s.jump) c = 9'b001000000;
        else           c = 9'b000000000;
        return {c, m_err, CW'(m_stall)};
    endfunction

    task automatic model_step(input stim_t s, input bit pc_stall);
        if (pc_stall && m_stall < (1 << CW) - 1) m_stall++;
        if (m_state == 0) begin
            m_cnt = 0;
            if (s.acc && !s.rdy) m_state = 1;
        end else if (s.rdy) begin
            m_state = 0;
            m_cnt   = 0;
        end else if (m_cnt == TO - 1) begin
            m_state = 0;
            m_cnt   = 0;
            m_err   = 1;
        end else begin
            m_cnt++;
        end
    endtask

    task automatic model_reset();
        m_state = 0;
        m_cnt   = 0;
        m_stall = 0;
        m_err   = 0;
    endtask

    task automatic apply(input stim_t s);
        ID_Rs = s.rs; ID_Rt = s.rt; ID_UsesRs = s.urs; ID_UsesRt = s.urt;
        ID_Jump = s.jump; EX_MemRead = s.ex_mr; EX_RegWre = s.ex_rw;
        EX_RegDst = s.dst; EX_BranchTaken = s.br;
        MEM_MemAccess = s.acc; dmem_ready = s.rdy;
    endtask

    // driver: one cycle of stimulus with scoreboard push/pop
    task automatic cyc(input stim_t s);
        logic [EXPW-1:0] e;
        logic [EXPW-1:0] g;
        @(negedge clk);
        apply(s);
        exp_q.push_back(model_expect(s));
        #1;
        g = {got_ctrl(), mem_err, stall_cycles};
        e = exp_q.pop_front();
        check_eq("ctrl", 32'(g[EXPW-1:CW+1]), 32'(e[EXPW-1:CW+1]));
        check_eq("mem_err", 32'(g[CW]), 32'(e[CW]));
        check_eq("stall_cycles", 32'(g[CW-1:0]), 32'(e[CW-1:0]));
        model_step(s, e[EXPW-1]);
    endtask

    function automatic stim_t lw(input logic [4:0] dst);
        stim_t s;
        s = '0;
        s.ex_mr = 1'b1;
        s.ex_rw = 1'b1;
        s.dst   = dst;
        return s;
    endfunction

    initial begin
        stim_t s;

        // Reset with hazardous inputs present: everything must read zero.
        rst = 1'b1;
        s = idle(); s.acc = 1'b1; s.br = 1'b1; s.jump = 1'b1;
        apply(s);
        #1;
        check_eq("rst_ctrl", 32'(got_ctrl()), 32'd0);
        check_eq("rst_mem_err", 32'(mem_err), 32'd0);
        check_eq("rst_stall_cycles", 32'(stall_cycles), 32'd0);
        @(negedge clk);
        apply(idle());
        rst = 1'b0;

        // Load-use on Rs, then the bubble cycle, then on Rt.
        s = lw(5'd5); s.rs = 5'd5; s.urs = 1'b1;
        cyc(s);
        cyc(idle());
        check_eq("lu_stall_cycles", 32'(stall_cycles), 32'd1);
        s = lw(5'd7); s.rt = 5'd7; s.urt = 1'b1; s.rs = 5'd7;
        cyc(s);
        cyc(idle());

        // r0 destination and unused source never stall.
        s = lw(5'd0); s.rs = 5'd0; s.urs = 1'b1; s.rt = 5'd0; s.urt = 1'b1;
        cyc(s);
        s = lw(5'd5); s.rs = 5'd5; s.urs = 1'b0;
        cyc(s);
        s = lw(5'd5); s.rs = 5'd5; s.urs = 1'b1; s.ex_rw = 1'b0;
        cyc(s);

        // Branch over load-use, jump held by load-use, jump alone.
        s = lw(5'd3); s.rs = 5'd3; s.urs = 1'b1; s.br = 1'b1;
        cyc(s);
        s = lw(5'd3); s.rt = 5'd3; s.urt = 1'b1; s.jump = 1'b1;
        cyc(s);
        s = idle(); s.jump = 1'b1;
        cyc(s);

        // Store waits three cycles with a branch pending; branch applies on release.
        for (int i = 0; i < 3; i++) begin
            s = idle(); s.acc = 1'b1; s.br = 1'b1; s.jump = 1'b1;
            cyc(s);
        end
        s = idle(); s.acc = 1'b1; s.rdy = 1'b1; s.br = 1'b1;
        cyc(s);
        cyc(idle());

        // Single-cycle hit never stalls.
        s = idle(); s.acc = 1'b1; s.rdy = 1'b1;
        cyc(s);

        // Timeout: four stalled cycles, release, sticky error.
        for (int i = 0; i < 5; i++) begin
            s = idle(); s.acc = 1'b1;
            cyc(s);
        end
        for (int i = 0; i < 4; i++) cyc(idle());
        check_eq("mem_err_sticky", 32'(mem_err), 32'd1);

        // Random traffic.
        for (int i = 0; i < 300; i++) begin
            s.rs    = 5'($urandom_range(0, 3));
            s.rt    = 5'($urandom_range(0, 3));
            s.dst   = 5'($urandom_range(0, 3));
            s.urs   = 1'($urandom_range(0, 1));
            s.urt   = 1'($urandom_range(0, 1));
            s.ex_mr = 1'($urandom_range(0, 1));
            s.ex_rw = 1'($urandom_range(0, 1));
            s.jump  = ($urandom_range(0, 3) == 0);
            s.br    = ($urandom_range(0, 4) == 0);
            s.acc   = ($urandom_range(0, 3) == 0);
            s.rdy   = 1'($urandom_range(0, 1));
            cyc(s);
        end

        // Continuous misses drive the counter into saturation.
        for (int i = 0; i < 350; i++) begin
            s = idle(); s.acc = 1'b1;
            cyc(s);
        end
        cyc(idle());
        check_eq("stall_sat", 32'(stall_cycles), 32'd255);

        // Async reset between edges while waiting on memory.
        s = idle(); s.acc = 1'b1;
        cyc(s);
        cyc(s);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_eq("midrst_ctrl", 32'(got_ctrl()), 32'd0);
        check_eq("midrst_mem_err", 32'(mem_err), 32'd0);
        check_eq("midrst_stall_cycles", 32'(stall_cycles), 32'd0);
        model_reset();
        apply(idle());
        @(negedge clk);
        rst = 1'b0;
        cyc(idle());
        s = lw(5'd9); s.rs = 5'd9; s.urs = 1'b1;
        cyc(s);
        cyc(idle());

        // final report
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
